// File: rtl/seq_logic_unit.sv
// seq_logic_unit: multi-cycle bitwise logic unit.
// Operands and opcode are captured on start, the word is evaluated SLICE bits
// per cycle (LSB slice first) into a working register, and only the completed
// word is published on result/zero together with a one-cycle done pulse.
// WIDTH must be an exact multiple of SLICE.
module seq_logic_unit #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSL = WIDTH / SLICE;
    localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSL - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r, wrk, wrk_nxt;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] sa, sb, sy;
    int               base;

    // Per-bit logic op over one slice.
    function automatic logic [SLICE-1:0] lop(input logic [2:0] o,
                                             input logic [SLICE-1:0] x,
                                             input logic [SLICE-1:0] y);
        case (o)
            3'b000:  return x & y;
            3'b001:  return x | y;
            3'b010:  return x ^ y;
            3'b011:  return ~(x | y);
            3'b100:  return ~(x & y);
            3'b101:  return ~(x ^ y);
            3'b110:  return x & ~y;
            default: return x;
        endcase
    endfunction

    // Select the current slice and merge its result into the working word.
    always_comb begin
        base    = int'(cnt) * SLICE;
        sa      = a_r[base +: SLICE];
        sb      = b_r[base +: SLICE];
        sy      = lop(op_r, sa, sb);
        wrk_nxt = wrk;
        wrk_nxt[base +: SLICE] = sy;
    end

    // Control FSM, operand capture and result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            wrk    <= '0;
            cnt    <= '0;
            result <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    wrk <= wrk_nxt;
                    cnt <= cnt + 1'b1;
                    // Last slice: publish the finished word on the same edge.
                    if (cnt == LAST) begin
                        state  <= S_DONE;
                        result <= wrk_nxt;
                        zero   <= (wrk_nxt == '0);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_logic_unit.sv
// Scoreboard bench for seq_logic_unit: three instances (5/1, 32/8, 32/32).
// Stimulus pushes expected {result, zero, done cycle}; a negedge monitor pops
// on every done pulse and also checks result stability while busy.
module tb_seq_logic_unit;

    typedef struct {
        logic [31:0] res;
        logic        z;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst, rst32;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic       st5, busy5, done5, z5;
    logic [2:0] op5;
    logic [4:0] a5, b5, res5;

    logic        st32, busy32, done32, z32;
    logic [2:0]  op32;
    logic [31:0] a32, b32, res32;

    logic        st1, busy1, done1, z1;
    logic [2:0]  op1;
    logic [31:0] a1, b1, res1;

    seq_logic_unit #(.WIDTH(5), .SLICE(1)) u5 (
        .clk(clk), .reset(rst), .start(st5), .op(op5), .a(a5), .b(b5),
        .busy(busy5), .done(done5), .result(res5), .zero(z5));

    seq_logic_unit #(.WIDTH(32), .SLICE(8)) u32 (
        .clk(clk), .reset(rst32), .start(st32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .zero(z32));

    seq_logic_unit #(.WIDTH(32), .SLICE(32)) u1 (
        .clk(clk), .reset(rst), .start(st1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .result(res1), .zero(z1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Uniform views of the three instances for the monitor.
    logic        dn[3], bs[3], zz[3], rs_i[3];
    logic [31:0] rv[3];
    assign dn[0] = done5;  assign dn[1] = done32;  assign dn[2] = done1;
    assign bs[0] = busy5;  assign bs[1] = busy32;  assign bs[2] = busy1;
    assign zz[0] = z5;     assign zz[1] = z32;     assign zz[2] = z1;
    assign rs_i[0] = rst;  assign rs_i[1] = rst32; assign rs_i[2] = rst;
    assign rv[0] = {27'b0, res5};
    assign rv[1] = res32;
    assign rv[2] = res1;

    int          nsl[3] = '{5, 4, 1};
    int          bcnt[3] = '{0, 0, 0};
    logic [31:0] last[3] = '{32'h0, 32'h0, 32'h0};
    exp_t        q[3][$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
        checks++;
        if (act !== exv) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exv);
        end
    endtask

    // Monitor: pop and compare on each done pulse; result must hold while busy.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rs_i[i] === 1'b1) begin
                bcnt[i] = 0;
            end else begin
                if (bs[i] === 1'b1) begin
                    bcnt[i]++;
                    chk($sformatf("hold[%0d]", i), rv[i], last[i]);
                end
                if (dn[i] === 1'b1) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_done[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("result[%0d]", i), rv[i], e.res);
                        chk($sformatf("zero[%0d]", i), {31'b0, zz[i]}, {31'b0, e.z});
                        chk($sformatf("done_cycle[%0d]", i), cyc, e.cyc);
                        chk($sformatf("busy_len[%0d]", i), bcnt[i], nsl[i]);
                        last[i] = e.res;
                    end
                    bcnt[i] = 0;
                end
            end
        end
    end

    task automatic put(input int i, input logic s, input logic [2:0] o,
                       input logic [31:0] av, input logic [31:0] bv);
        case (i)
            0: begin st5 = s; op5 = o; a5 = av[4:0]; b5 = bv[4:0]; end
            1: begin st32 = s; op32 = o; a32 = av; b32 = bv; end
            default: begin st1 = s; op1 = o; a1 = av; b1 = bv; end
        endcase
    endtask

    task automatic expect_op(input int i, input logic [31:0] r, input int c);
        exp_t e;
        e.res = r;
        e.z   = (r == 32'h0);
        e.cyc = c;
        q[i].push_back(e);
    endtask

    task automatic wait_q(input int i);
        for (int n = 0; n < 60 && q[i].size() != 0; n++) @(posedge clk);
        if (q[i].size() != 0) begin
            chk($sformatf("timeout[%0d]", i), q[i].size(), 0);
            q[i].delete();
        end
        @(negedge clk);
    endtask

    // Single operation: start for one cycle; done expected NSL+1 edges later.
    task automatic run_op(input int i, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic [31:0] r);
        @(posedge clk); #1;
        put(i, 1'b1, o, av, bv);
        expect_op(i, r, cyc + 1 + nsl[i]);
        @(posedge clk); #1;
        put(i, 1'b0, o, av, bv);
        wait_q(i);
    endtask

    initial begin
        int k;
        rst = 1'b1; rst32 = 1'b1;
        for (int i = 0; i < 3; i++) put(i, 1'b0, 3'b000, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rst32 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_busy[%0d]", i), {31'b0, bs[i]}, 32'd0);
            chk($sformatf("rst_done[%0d]", i), {31'b0, dn[i]}, 32'd0);
            chk($sformatf("rst_result[%0d]", i), rv[i], 32'd0);
            chk($sformatf("rst_zero[%0d]", i), {31'b0, zz[i]}, 32'd1);
        end

        // 5-bit, one bit per cycle
        run_op(0, 3'b000, 32'b00010, 32'b11100, 32'b00000);
        run_op(0, 3'b000, 32'b10101, 32'b01101, 32'b00101);
        run_op(0, 3'b001, 32'b10101, 32'b01101, 32'b11101);
        run_op(0, 3'b010, 32'b10101, 32'b01101, 32'b11000);

        // 32-bit, 8-bit slices: NOR
        run_op(1, 3'b011, 32'h0F0F_0000, 32'h00F0_00FF, 32'hF000_FF00);

        // Back-to-back ANDN with start held high; A disturbed mid-RUN of op 1
        @(posedge clk); #1;
        put(1, 1'b1, 3'b110, 32'hFFFF_FFFF, 32'h1234_5678);
        k = cyc;
        for (int j = 0; j < 3; j++) expect_op(1, 32'hEDCB_A987, k + 5 + 5 * j);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (n == 2) a32 = 32'h0000_0000;
            if (n == 4) a32 = 32'hFFFF_FFFF;
        end
        st32 = 1'b0;
        wait_q(1);

        // PASSA aborted by reset on the second busy cycle
        @(posedge clk); #1;
        put(1, 1'b1, 3'b111, 32'hDEAD_BEEF, 32'h0);
        @(posedge clk); #1;
        st32 = 1'b0;
        @(posedge clk); #1;
        rst32 = 1'b1;
        @(posedge clk); #1;
        rst32 = 1'b0;
        last[1] = 32'h0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy32}, 32'd0);
        chk("abort_done", {31'b0, done32}, 32'd0);
        chk("abort_result", res32, 32'd0);
        chk("abort_zero", {31'b0, z32}, 32'd1);
        repeat (10) @(posedge clk);
        run_op(1, 3'b111, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);

        // SLICE == WIDTH: single RUN cycle
        run_op(2, 3'b101, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF);

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
Multi-cycle, parametrised bitwise logic unit. It is the sequential successor to the fixed 5-bit combinational AND block and feeds the ALU logic path. Operands and opcode are latched on a start handshake. The operation is evaluated SLICE bits per cycle, LSB slice first, and the full word is presented with a one-cycle done pulse plus a zero flag. The unit supports eight logic ops at any WIDTH that is a multiple of SLICE.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of SLICE, minimum 1.
SLICE, 8, bits evaluated per RUN cycle; NSL = WIDTH/SLICE RUN cycles per operation.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE
op  input  3  operation select, latched with start
a  input  WIDTH  operand A, latched with start
b  input  WIDTH  operand B, latched with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result/zero valid from this cycle
result  output  WIDTH  last completed result, held until next completion
zero  output  1  high when result == 0, updated with result

Behaviour:
- Reset is synchronous and active-high, on clk rising edge. Reset → state IDLE, busy=0, done=0, result=0, zero=1. Internal operand regs, working reg and slice counter are all cleared.
- Reset during RUN or DONE aborts the operation with no done pulse. result returns to 0; the previous result is not retained.
- Opcodes (bitwise, per bit):
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 NAND
  - 101 XNOR
  - 110 ANDN (A & ~B)
  - 111 PASSA (A)
- FSM states: IDLE, RUN, DONE.
  - IDLE: busy=0, done=0. start=1 → latch a, b, op; cnt=0; go to RUN. start=0 → stay.
  - RUN: busy=1. Each cycle evaluates slice cnt (bits cnt*SLICE+SLICE-1 .. cnt*SLICE) of the latched operands into the working reg, then cnt++. The cycle that evaluates slice NSL-1 → go to DONE. result/zero load from the completed working word on that same edge.
  - DONE: busy=0, done=1 for exactly this one cycle. start=1 → latch new operands, go to RUN (back-to-back accepted). Otherwise → IDLE.
- Latency: start sampled at edge T → RUN for edges T+1..T+NSL → done=1 in the cycle after edge T+NSL.
- Throughput: one op per NSL+1 cycles.
- start during RUN is ignored, not queued. a, b and op changes during RUN have no effect.
- Partial words never appear on result. result changes only on the edge entering DONE, or on reset.
- SLICE == WIDTH → NSL=1: single RUN cycle, done two cycles after start.
- Counter width is clog2(NSL), minimum 1 bit. cnt is reset to 0 on every accepted start.
- result and zero remain stable through IDLE and any following RUN until the next DONE.

Test Plan:
1. WIDTH=5, SLICE=1, op=000, A=00010, B=11100, start 1 cycle → busy 5 cycles, done pulse on cycle 6, result=00000, zero=1.
2. WIDTH=5, SLICE=1, op=000, A=10101, B=01101 → result=00101, zero=0. Then op=001 (OR) → 11101. Then op=010 (XOR) → 11000. Each op gives exactly one done pulse.
3. WIDTH=32, SLICE=8, op=011 (NOR), A=0x0F0F_0000, B=0x00F0_00FF → done exactly 5 cycles after start, result=0xF000_FF00. result holds old value during the 4 busy cycles.
4. WIDTH=32, SLICE=8, op=110 (ANDN), A=0xFFFF_FFFF, B=0x1234_5678. Hold start high continuously → accepted in DONE, back-to-back ops every 5 cycles, each result=0xEDCB_A987. Toggling A mid-RUN does not alter that op's result.
5. WIDTH=32, SLICE=8: start op=111 (PASSA), A=0xDEAD_BEEF; assert reset on the 2nd busy cycle → next cycle busy=0, done=0, result=0, zero=1, no done pulse ever; a fresh start afterward completes normally.
6. WIDTH=32, SLICE=32, op=101 (XNOR), A=B=0xA5A5_A5A5 → single busy cycle, done cycle after, result=0xFFFF_FFFF, zero=0.
